spi_receiver: RTL
=================

SPI_RECEIVER -- requirements
Module: spi_receiver

Interface
REQ-001 Parameter p_data_width, default 8: bits per received word; legal range 2..32.
REQ-002 Parameter p_cpol, default 0: sck idle level.
REQ-003 Parameter p_cpha, default 0: 0 = sample on leading sck edge, 1 = sample on trailing sck edge.
REQ-004 Parameter p_msb_first, default 1: 1 = first received bit lands in data[p_data_width-1], 0 = in data[0].
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 s_rst_n  input  1  reset, synchronous to clk, active-low.
REQ-007 sck  input  1  SPI serial clock, asynchronous to clk.
REQ-008 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-009 mosi  input  1  SPI serial data, asynchronous.
REQ-010 data  output  p_data_width  received word; stable while valid=1.
REQ-011 valid  output  1  data holds an unconsumed word.
REQ-012 ready  input  1  consumer accepts data when valid=1 and ready=1 on a clk edge.
REQ-013 overrun  output  1  one-clk pulse: a completed word was dropped.
REQ-014 frame_err  output  1  one-clk pulse: cs_n deasserted with a partial word.
REQ-015 busy  output  1  high while FSM is in SHIFT.

Function
REQ-016 sck, cs_n and mosi each pass through a 2-flop synchronizer, plus a third flop on sck and cs_n for edge detection; mosi uses the same depth so it stays aligned with sck.
REQ-017 Sampling edge: rising when p_cpol xor p_cpha = 0, otherwise falling; detected from synchronized sck only.
REQ-018 Supported sck high and low times: each >= 3 clk periods; behaviour is undefined for faster sck.
REQ-019 FSM states: IDLE, SHIFT.
REQ-020 IDLE -> SHIFT on a synchronized cs_n falling edge only; bit counter and shift register clear on that edge.
REQ-021 SHIFT -> IDLE on a synchronized cs_n rising edge.
REQ-022 In SHIFT, each sampling edge shifts in mosi per p_msb_first and increments the bit counter.
REQ-023 On the p_data_width-th bit the word completes, the counter returns to 0, and SHIFT continues; multiple words per cs_n frame are allowed.
REQ-024 Completion with valid=0, or with valid=1 and ready=1 in the same cycle: load data and set valid=1 on the next clk edge.
REQ-025 Completion with valid=1 and ready=0: the new word is dropped, data and valid are held, and overrun pulses for 1 clk.
REQ-026 Accept with no completion: valid=0 on the next edge; data holds its last value.
REQ-027 valid rises exactly 1 clk after the cycle in which the last sampling edge is detected, i.e. 4 clk after the physical sck edge.
REQ-028 cs_n rising edge with counter != 0: the partial word is discarded, frame_err pulses for 1 clk, and valid/data are unaffected.
REQ-029 cs_n rising edge with counter = 0: no pulse.
REQ-030 Sampling edges while in IDLE are ignored.
REQ-031 If completion and a cs_n rising edge occur in the same cycle, the word is delivered per REQ-024/025 and no frame_err is raised.

Reset
REQ-032 While s_rst_n=0 on a clk edge: data=0, valid=0, overrun=0, frame_err=0, busy=0, FSM=IDLE, counter=0, shift register=0.
REQ-033 During reset, the sck synchronizer flops load p_cpol and the cs_n flops load 1.
REQ-034 After reset is released mid-frame (cs_n low), the rest of that frame is ignored; the receiver waits in IDLE for a fresh cs_n falling edge.

Verification
REQ-035 Mode 0, MSB first, ready=1, one frame sending 8'h14 -> valid pulses for 1 clk with data=8'h14, 4 clk after the 8th rising sck edge; frame_err=0.
REQ-036 One frame sending 8'h03 then 8'h57, ready=1 -> two valid beats with data 8'h03 then 8'h57; busy stays high across both words.
REQ-037 ready=0, frame sending 8'h45 then 8'hAA -> data stays 8'h45 with valid=1; overrun pulses once at completion of the 2nd word.
REQ-038 Frame of 5 bits then cs_n high -> frame_err pulses once; valid stays 0; the next 8-bit frame 8'h3C is received correctly.
REQ-039 s_rst_n=0 for 2 clk after bit 4 of a frame (cs_n held low) -> all outputs 0; the remaining bits produce no valid; the following frame 8'h81 is received.
REQ-040 p_cpol=1, p_cpha=1, p_msb_first=0, sending bits 1,0,1,0,0,0,0,0 in time order -> data=8'h05.

Source files
------------

// File: rtl/spi_receiver.sv
// SPI slave receiver: synchronizes sck/cs_n/mosi into clk, shifts words in on the
// selected sck edge and hands them out on a valid/ready interface.
module spi_receiver #(
    parameter int p_data_width = 8,
    parameter int p_cpol       = 0,
    parameter int p_cpha       = 0,
    parameter int p_msb_first  = 1
) (
    input  logic                    clk,
    input  logic                    s_rst_n,
    input  logic                    sck,
    input  logic                    cs_n,
    input  logic                    mosi,
    output logic [p_data_width-1:0] data,
    output logic                    valid,
    input  logic                    ready,
    output logic                    overrun,
    output logic                    frame_err,
    output logic                    busy
);

    // state    | meaning
    // ST_IDLE  | waiting for a synchronized cs_n falling edge
    // ST_SHIFT | frame open, shifting mosi on each sampling edge
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam int CW = (p_data_width > 2) ? $clog2(p_data_width) : 1;
    localparam logic [CW-1:0] LAST = CW'(p_data_width - 1);
    localparam logic CPOL_B = 1'(p_cpol);
    localparam bit SAMPLE_RISE = ((p_cpol ^ p_cpha) & 1) == 0;
    localparam bit MSB_FIRST = (p_msb_first != 0);

    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [p_data_width-1:0] shift_q;
    logic [p_data_width-1:0] data_q;
    logic                    done_q;
    logic                    valid_q;
    logic                    overrun_q;
    logic                    frame_err_q;
    logic [1:0]              settle_q;
    logic                    armed_q;

    logic                    sample_d;
    logic                    cs_fall_d;
    logic                    cs_rise_d;
    logic [p_data_width-1:0] shift_d;
    logic                    partial_d;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            sck_q  <= {3{CPOL_B}};
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            cs_q   <= {cs_q[1:0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    always_comb begin
        sample_d  = SAMPLE_RISE ? (sck_q[1] & ~sck_q[2]) : (~sck_q[1] & sck_q[2]);
        cs_fall_d = ~cs_q[1] & cs_q[2];
        cs_rise_d = cs_q[1] & ~cs_q[2];
        if (MSB_FIRST) shift_d = {shift_q[p_data_width-2:0], mosi_q[1]};
        else           shift_d = {mosi_q[1], shift_q[p_data_width-1:1]};
        partial_d = sample_d ? (cnt_q != LAST) : (cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            // Only arm once the synchronizers hold real cs_n and it has been seen high,
            // so a frame already in progress at reset release is ignored.
            if (settle_q == 2'd3 && cs_q[2]) armed_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_d && armed_q) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (sample_d) begin
                        shift_q <= shift_d;
                        if (cnt_q == LAST) begin
                            cnt_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    if (cs_rise_d) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        if (partial_d) frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Completed word is handed over one clk after it lands in shift_q.
            if (done_q) begin
                if (!valid_q || ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule
